// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter
// ----------------------------------------------------------------------------
// Two-requester round-robin arbiter in front of one single-port synchronous
// RAM. The RAM returns read data one cycle after mem_re.
//
// Each cycle at most one command (read or write) is accepted from one
// requester. That command is driven onto the RAM lines in the same cycle.
// Read data coming back from the RAM is steered to the requester that issued
// the read, and is marked by that requester's rvalid strobe.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   reqN, weN         requester N command valid; 1 = write, 0 = read
//   addrN, wdataN     requester N address and write data, held until ackN
//   ackN              requester N command consumed on this rising edge
//   rvalidN, rdataN   read result for requester N (rdataN valid when rvalidN)
//   mem_we, mem_re    RAM write / read enable (never both high)
//   mem_addr          RAM address
//   mem_wdata         RAM write data
//   mem_rdata         RAM registered read data, valid the cycle after mem_re
// ----------------------------------------------------------------------------
module ram_rr_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // requester 0
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  // requester 1
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  // RAM side
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // last_gnt_q holds the index of the most recently granted requester. Its
  // reset value is 1, so requester 0 wins the first contended cycle.
  logic last_gnt_q, last_gnt_d;
  logic rvalid0_q,  rvalid0_d;
  logic rvalid1_q,  rvalid1_d;
  logic gnt0, gnt1;

  // --------------------------------------------------------------------------
  // Grant selection. rst_n is included here so that ack and the RAM enables
  // are forced low combinationally while reset is asserted, and not only
  // after the next clock edge.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (req0 && (!req1 || last_gnt_q)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign ack0 = gnt0;
  assign ack1 = gnt1;

  // --------------------------------------------------------------------------
  // RAM drive. With no grant the mux defaults to requester 0. The enables are
  // both low in that case, so the address and data values are don't-care.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_addr  = gnt1 ? addr1  : addr0;
    mem_wdata = gnt1 ? wdata1 : wdata0;
    mem_we    = (gnt0 &&  we0) || (gnt1 &&  we1);
    mem_re    = (gnt0 && !we0) || (gnt1 && !we1);
  end

  // --------------------------------------------------------------------------
  // Next state. last_gnt holds its value when no command is accepted. Each
  // accepted read raises the issuer's rvalid for exactly the next cycle, which
  // is the cycle in which the RAM presents the data.
  // --------------------------------------------------------------------------
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt0) begin
      last_gnt_d = 1'b0;
    end else if (gnt1) begin
      last_gnt_d = 1'b1;
    end
    rvalid0_d = gnt0 && !we0;
    rvalid1_d = gnt1 && !we1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples values from before the edge, whatever the order of statements.
      last_gnt_q <= 1'b1;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;

  // There is only one RAM read port, and only one read is outstanding at a
  // time. Both requesters can therefore see the RAM output directly. The
  // rvalid strobes decide which requester owns the data.
  assign rdata0 = mem_rdata;
  assign rdata1 = mem_rdata;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// tb_ram_rr_arbiter
// ----------------------------------------------------------------------------
// Directed testbench for ram_rr_arbiter. The bench contains a behavioural
// single-port RAM with a one-cycle registered read. A shadow copy of the
// expected RAM contents is updated only from the writes that the bench issues.
// Inputs change 1 time unit after a rising edge, and outputs are sampled
// 1 time unit after that.
// ----------------------------------------------------------------------------
module tb_ram_rr_arbiter;

  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic          preload;
  logic [DW-1:0] ram    [1<<AW];
  logic [DW-1:0] shadow [1<<AW];

  ram_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .ack0     (ack0),
    .rvalid0  (rvalid0),
    .rdata0   (rdata0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .ack1     (ack1),
    .rvalid1  (rvalid1),
    .rdata1   (rdata1),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM. While preload is high it is filled with 0x10 + address.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= DW'(8'h10 + i);
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic r1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) shadow[i] = DW'(8'h10 + i);
    mem_rdata = '0;

    // ---------------- reset with both requesters active ----------------
    rst_n   = 1'b0;
    preload = 1'b1;
    drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00);
    #3;
    check("rst_ack0",    32'(ack0),    32'd0);
    check("rst_ack1",    32'(ack1),    32'd0);
    check("rst_mem_we",  32'(mem_we),  32'd0);
    check("rst_mem_re",  32'(mem_re),  32'd0);
    check("rst_rvalid0", 32'(rvalid0), 32'd0);
    check("rst_rvalid1", 32'(rvalid1), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_clk_acks",   32'({ack0, ack1}),       32'd0);
    check("rst_clk_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
    preload = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_first_gnt", 32'({ack0, ack1}), 32'b10);
    tick();
    idle();
    #1;
    check("rst_first_rvalid", 32'({rvalid0, rvalid1}), 32'b10);
    check("rst_first_rdata",  32'(rdata0),             32'(shadow[0]));

    // ---------------- single write then read, requester 0 ----------------
    tick();
    drive(1'b1, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b0, 3'd0, 8'h00);
    #1;
    check("wr_ack0",      32'({ack0, ack1}),     32'b10);
    check("wr_enables",   32'({mem_we, mem_re}), 32'b10);
    check("wr_mem_addr",  32'(mem_addr),         32'd3);
    check("wr_mem_wdata", 32'(mem_wdata),        32'hA5);
    shadow[3] = 8'hA5;
    tick();
    drive(1'b1, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    #1;
    check("wr_no_rvalid", 32'({rvalid0, rvalid1}), 32'b00);
    check("rd_ack0",      32'({ack0, ack1}),       32'b10);
    check("rd_enables",   32'({mem_we, mem_re}),   32'b01);
    tick();
    idle();
    #1;
    check("rd_rvalid",    32'({rvalid0, rvalid1}), 32'b10);
    check("rd_rdata0",    32'(rdata0),             32'hA5);

    // ---------------- read-after-write across requesters ----------------
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd7, 8'h3C);
    #1;
    check("raw_wr_ack",  32'({ack0, ack1}),     32'b01);
    check("raw_wr_en",   32'({mem_we, mem_re}), 32'b10);
    check("raw_wr_addr", 32'(mem_addr),         32'd7);
    check("raw_wr_data", 32'(mem_wdata),        32'h3C);
    shadow[7] = 8'h3C;
    tick();
    drive(1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    #1;
    check("raw_rd_ack",  32'({ack0, ack1}), 32'b10);
    check("raw_rd_addr", 32'(mem_addr),     32'd7);
    tick();
    idle();
    #1;
    check("raw_rvalid", 32'({rvalid0, rvalid1}), 32'b10);
    check("raw_rdata0", 32'(rdata0),             32'h3C);

    // ---------------- idle, then requester 1 alone ----------------
    tick();
    #1;
    check("idle_enables", 32'({mem_we, mem_re}), 32'b00);
    check("idle_acks",    32'({ack0, ack1}),     32'b00);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, AW'(k), 8'h00);
      #1;
      check($sformatf("solo1_ack_%0d", k), 32'({ack0, ack1}), 32'b01);
      if (k > 0) begin
        check($sformatf("solo1_rvalid_%0d", k), 32'({rvalid0, rvalid1}), 32'b01);
        check($sformatf("solo1_rdata_%0d", k),  32'(rdata1), 32'(shadow[k-1]));
      end
      tick();
    end

    // ---------------- contention: both requesters read addr 0..5 ----------------
    // In cycle k the granted requester reads address k. Requester 0 takes the
    // even addresses and requester 1 the odd ones, and each holds its address
    // until it is acked.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, AW'((k + 1) & ~1), 8'h00, 1'b1, 1'b0, AW'(k | 1), 8'h00);
      #1;
      check($sformatf("cont_ack_%0d", k),  32'({ack0, ack1}),
            (k % 2 == 0) ? 32'b10 : 32'b01);
      check($sformatf("cont_addr_%0d", k), 32'(mem_addr), 32'(k));
      check($sformatf("cont_en_%0d", k),   32'({mem_we, mem_re}), 32'b01);
      if (k == 0) begin
        check("cont_prev_rvalid_0", 32'({rvalid0, rvalid1}), 32'b01);
        check("cont_prev_rdata_0",  32'(rdata1), 32'(shadow[2]));
      end else begin
        check($sformatf("cont_rvalid_%0d", k), 32'({rvalid0, rvalid1}),
              ((k - 1) % 2 == 0) ? 32'b10 : 32'b01);
        check($sformatf("cont_rdata_%0d", k),
              ((k - 1) % 2 == 0) ? 32'(rdata0) : 32'(rdata1), 32'(shadow[k-1]));
      end
      tick();
    end
    idle();
    #1;
    check("cont_last_rvalid", 32'({rvalid0, rvalid1}), 32'b01);
    check("cont_last_rdata",  32'(rdata1),             32'(shadow[5]));

    // ---------------- asynchronous reset between a read ack and its return ----------------
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd4, 8'h00);
    #1;
    check("arst_rd_ack", 32'({ack0, ack1}), 32'b01);
    tick();
    idle();
    #1;
    check("arst_pre_rvalid", 32'({rvalid0, rvalid1}), 32'b01);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_rvalid_drop", 32'({rvalid0, rvalid1}), 32'b00);
    tick();
    check("arst_rvalid_hold", 32'({rvalid0, rvalid1}), 32'b00);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00);
    #1;
    check("arst_first_gnt", 32'({ack0, ack1}), 32'b10);
    tick();
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares one single-port synchronous RAM.
- The RAM has registered read data with 1-cycle latency and write/read enables.
- Each cycle the arbiter accepts at most one command (read or write) from one requester and drives the RAM control/address/data lines.
- It routes the returned read data back to the requester that issued the read, tagged with a valid strobe.

Parameters:
- ADDR_WIDTH, 3, RAM address width
- DATA_WIDTH, 8, RAM data width

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req0  input  1  requester 0 command valid
- we0  input  1  requester 0: 1=write, 0=read
- addr0  input  ADDR_WIDTH  requester 0 address
- wdata0  input  DATA_WIDTH  requester 0 write data
- ack0  output  1  requester 0 command accepted this cycle
- rvalid0  output  1  rdata0 holds read result for requester 0
- rdata0  output  DATA_WIDTH  requester 0 read data
- req1, we1, addr1, wdata1, ack1, rvalid1, rdata1: same as requester 0, for requester 1
- mem_we  output  1  RAM write enable
- mem_re  output  1  RAM read enable
- mem_addr  output  ADDR_WIDTH  RAM address
- mem_wdata  output  DATA_WIDTH  RAM write data
- mem_rdata  input  DATA_WIDTH  RAM registered read data (valid cycle after mem_re)

Behaviour:
Reset:
- Asynchronous, active-low. While rst_n=0: rvalid0=rvalid1=0, last_gnt=1 (requester 0 has priority first).
- ack0=ack1=mem_we=mem_re=0 are forced combinationally while rst_n=0.
- rdata0/rdata1/mem_addr/mem_wdata are don't-care during reset.

Handshake:
- A requester raises reqN with we/addr/wdata stable and holds them until ackN=1.
- ackN is combinational, asserted in the cycle the command is driven to the RAM. The command is consumed on that rising edge.
- reqN may stay high after ack to issue the next command back-to-back.

Arbitration:
- Only one req high: that requester is granted.
- Both high: grant goes to the requester not equal to last_gnt.
- last_gnt updates to the granted index on each accepted command and holds when idle.
- Two persistent requesters therefore strictly alternate 0,1,0,1…; neither waits more than 1 cycle.
- At most one of ack0/ack1 is high in any cycle.

RAM drive, same cycle as ack:
- mem_addr = addrN.
- mem_wdata = wdataN.
- mem_we = weN.
- mem_re = ~weN.
- With no grant: mem_we=mem_re=0, and mem_addr/mem_wdata hold requester 0's values (don't-care).
- mem_we and mem_re are never both 1.

Read return:
- A read accepted at edge T sets registered rvalidN=1 for exactly the one cycle after edge T.
- rdataN = mem_rdata when rvalidN=1; rdata is don't-care otherwise.
- rvalid0 and rvalid1 are never both 1.
- Writes produce no rvalid.

Throughput and latency:
- Throughput: 1 command per cycle total.
- Read latency: ack cycle + 1.

Ordering:
- Commands execute in grant order.
- A write accepted at edge T followed by a read of the same address accepted at edge T+1 (either requester) returns the new data.

Reset mid-operation:
- A pending rvalid is cleared immediately and the read result is lost.
- Requesters must reissue after rst_n rises.
- First grant after reset favours requester 0.

Test Plan:
- Reset: rst_n=0 with req0=req1=1 -> ack0=ack1=mem_we=mem_re=rvalid0=rvalid1=0. Release reset -> first ack goes to requester 0.
- Single write then read: req0 write addr=3 data=0xA5, then req0 read addr=3 -> mem_we=1 in the ack cycle. Read ack is followed next cycle by rvalid0=1, rdata0=0xA5, rvalid1=0.
- Contention: req0 and req1 both held high for 6 cycles issuing reads of addr 0..5 (preloaded 0x10+addr) -> acks alternate 0,1,0,1,0,1. Each rvalid lands on the correct requester one cycle after its ack with the matching data.
- Read-after-write across requesters: req1 writes addr=7 data=0x3C in cycle T, req0 reads addr=7 in cycle T+1 -> rvalid0 at T+2 with rdata0=0x3C.
- Idle and priority retention: only req1 active for 3 cycles, then both -> requester 1 granted 3 times, then requester 0 granted first. No mem_we/mem_re when both req low.
- Async reset mid-read: assert rst_n=0 between a read ack and its return (not aligned to clk) -> rvalid drops immediately and stays 0. After release, last_gnt favours requester 0.
